rn_rename: RTL

Register-rename stage of the 4-wide out-of-order MIPS pipeline. Consumes the four-instruction group held in the ID/RN pipeline register and maps architectural sources and destinations to physical registers through a speculative RAT and a free list. Resolves intra-group dependencies and registers the renamed group toward dispatch. A retirement RAT updated by ROB commit provides single-cycle flush recovery.

---
 rtl/rn_pkg.sv | 37 +++
 rtl/rn_if.sv | 28 ++
 rtl/rn_free_list.sv | 70 +++++++
 rtl/rn_rename.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/rn_pkg.sv
// Shared types and sizes for the register-rename stage.
package rn_pkg;

  localparam int unsigned NUM_ARCH = 32;
  localparam int unsigned NUM_PHYS = 64;
  localparam int unsigned WIDTH    = 4;
  localparam int unsigned FL_DEPTH = 32;

  typedef logic [5:0] ptag_t;
  typedef logic [4:0] areg_t;
  typedef logic [4:0] fl_ptr_t;
  typedef logic [5:0] fl_cnt_t;

  // One lane of the ID/RN pipeline register.
  typedef struct packed {
    logic [8:0]  alu_op;
    logic        reg_w;
    logic        inst_valid;
    areg_t       src1;
    areg_t       src2;
    areg_t       rdst;
    logic [31:0] extend_imm;
  } rn_inst_t;

  // One lane of the RN/RR register toward dispatch.
  typedef struct packed {
    logic [8:0]  alu_op;
    logic        reg_w;
    logic        inst_valid;
    logic [31:0] extend_imm;
    ptag_t       psrc1;
    ptag_t       psrc2;
    ptag_t       pdst;
    ptag_t       old_pdst;
  } rr_inst_t;

endpackage

// File: rtl/rn_if.sv
// Rename-stage bus: ID/RN group in, RR group out, ROB commit and flush in.
interface rn_if import rn_pkg::*; ();

  logic                   flush;
  logic                   dis_stall;
  rn_inst_t [WIDTH-1:0]   rn_inst;
  logic [31:0]            rn_inst1_pc;
  logic                   rn_stall;
  rr_inst_t [WIDTH-1:0]   rr_inst;
  logic [31:0]            rr_inst1_pc;
  logic [WIDTH-1:0]       cm_valid;
  areg_t [WIDTH-1:0]      cm_rdst;
  ptag_t [WIDTH-1:0]      cm_pdst;
  ptag_t [WIDTH-1:0]      cm_old_pdst;

  // Front end / ROB side.
  modport master (
    output flush, dis_stall, rn_inst, rn_inst1_pc, cm_valid, cm_rdst, cm_pdst, cm_old_pdst,
    input  rn_stall, rr_inst, rr_inst1_pc
  );

  // Rename stage side.
  modport slave (
    input  flush, dis_stall, rn_inst, rn_inst1_pc, cm_valid, cm_rdst, cm_pdst, cm_old_pdst,
    output rn_stall, rr_inst, rr_inst1_pc
  );

endinterface

// File: rtl/rn_free_list.sv
// Circular free list of physical tags: up to WIDTH pops at head and WIDTH pushes
// at tail per cycle. commit_head tracks head as seen by retirement for flush restore.
module rn_free_list import rn_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic [2:0]            pop_cnt_i,
  output ptag_t [WIDTH-1:0]     pop_tags_o,
  input  logic [2:0]            push_cnt_i,
  input  ptag_t [WIDTH-1:0]     push_tags_i,
  output fl_cnt_t               count_o
);

  ptag_t   mem_q [FL_DEPTH];
  ptag_t   mem_d [FL_DEPTH];
  fl_ptr_t head_q, head_d;
  fl_ptr_t commit_head_q, commit_head_d;
  fl_ptr_t tail_q, tail_d;
  fl_cnt_t count_q, count_d;

  // Tags offered to the rename lanes, in allocation order.
  always_comb begin
    pop_tags_o = '0;
    for (int k = 0; k < WIDTH; k++) begin
      pop_tags_o[k] = mem_q[head_q + fl_ptr_t'(k)];
    end
  end

  assign count_o = count_q;

  // Push freed tags, advance pointers, restore head on flush.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < WIDTH; k++) begin
      if (3'(k) < push_cnt_i) begin
        mem_d[tail_q + fl_ptr_t'(k)] = push_tags_i[k];
      end
    end
    tail_d        = tail_q + {2'b0, push_cnt_i};
    commit_head_d = commit_head_q + {2'b0, push_cnt_i};
    if (flush_i) begin
      head_d  = commit_head_d;
      // The committed-free span always fills the ring, so equal pointers mean full.
      count_d = (tail_d == head_d) ? fl_cnt_t'(FL_DEPTH) : {1'b0, tail_d - head_d};
    end else begin
      head_d  = head_q + {2'b0, pop_cnt_i};
      count_d = count_q - {3'b0, pop_cnt_i} + {3'b0, push_cnt_i};
    end
  end

  // State register; reset loads tags 32..63 in order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem_q[i] <= ptag_t'(FL_DEPTH + i);
      end
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= '0;
      count_q       <= fl_cnt_t'(FL_DEPTH);
    end else begin
      mem_q         <= mem_d;
      head_q        <= head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: rtl/rn_rename.sv
// Register rename: speculative RAT, retirement RAT, intra-group dependency
// resolution and the RN/RR output register.
module rn_rename import rn_pkg::*; (
  input logic clk,
  input logic rst,
  rn_if.slave rn
);

  ptag_t rat_q  [NUM_ARCH];
  ptag_t rat_d  [NUM_ARCH];
  ptag_t rrat_q [NUM_ARCH];
  ptag_t rrat_d [NUM_ARCH];

  rr_inst_t [WIDTH-1:0] rr_q, rr_d;
  logic [31:0]          pc_q, pc_d;

  logic [WIDTH-1:0]     alloc;
  logic [2:0]           need;
  logic [2:0]           slot;
  logic                 shortfall;
  logic                 do_rename;
  fl_cnt_t              fl_count;
  ptag_t [WIDTH-1:0]    pop_tags;
  ptag_t [WIDTH-1:0]    pdst, psrc1, psrc2, old_pdst;
  logic [2:0]           push_cnt;
  ptag_t [WIDTH-1:0]    push_tags;

  // Allocating lanes and how many free tags the group needs.
  always_comb begin
    alloc = '0;
    need  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      alloc[k] = rn.rn_inst[k].inst_valid & rn.rn_inst[k].reg_w & (rn.rn_inst[k].rdst != '0);
      need     = need + {2'b0, alloc[k]};
    end
  end

  assign shortfall   = fl_count < {3'b0, need};
  assign do_rename   = !rn.flush && !rn.dis_stall && !shortfall;
  assign rn.rn_stall = rn.dis_stall | shortfall;

  // Tag assignment plus bypass from the youngest earlier lane writing the same register.
  always_comb begin
    slot     = '0;
    pdst     = '0;
    psrc1    = '0;
    psrc2    = '0;
    old_pdst = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (alloc[k]) pdst[k] = pop_tags[slot[1:0]];
      slot = slot + {2'b0, alloc[k]};
    end
    for (int k = 0; k < WIDTH; k++) begin
      psrc1[k]    = rat_q[rn.rn_inst[k].src1];
      psrc2[k]    = rat_q[rn.rn_inst[k].src2];
      old_pdst[k] = rat_q[rn.rn_inst[k].rdst];
      for (int j = 0; j < WIDTH; j++) begin
        if (j < k && alloc[j]) begin
          if (rn.rn_inst[j].rdst == rn.rn_inst[k].src1) psrc1[k]    = pdst[j];
          if (rn.rn_inst[j].rdst == rn.rn_inst[k].src2) psrc2[k]    = pdst[j];
          if (rn.rn_inst[j].rdst == rn.rn_inst[k].rdst) old_pdst[k] = pdst[j];
        end
      end
      if (rn.rn_inst[k].src1 == '0) psrc1[k] = '0;
      if (rn.rn_inst[k].src2 == '0) psrc2[k] = '0;
      if (!alloc[k])                old_pdst[k] = '0;
    end
  end

  // Commit into RRAT and collect freed tags; then RAT update from rename or flush.
  always_comb begin
    rrat_d    = rrat_q;
    push_cnt  = '0;
    push_tags = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (rn.cm_valid[i]) begin
        rrat_d[rn.cm_rdst[i]] = rn.cm_pdst[i];
        if (rn.cm_rdst[i] != '0) push_cnt = push_cnt + 3'd1;
      end
      push_tags[i] = rn.cm_old_pdst[i];
    end
    rat_d = rat_q;
    if (rn.flush) begin
      rat_d = rrat_d;
    end else if (do_rename) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (alloc[k]) rat_d[rn.rn_inst[k].rdst] = pdst[k];
      end
    end
  end

  rn_free_list u_free_list (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (rn.flush),
    .pop_cnt_i   (do_rename ? need : 3'd0),
    .pop_tags_o  (pop_tags),
    .push_cnt_i  (push_cnt),
    .push_tags_i (push_tags),
    .count_o     (fl_count)
  );

  // Output register: flush and shortfall bubble, dispatch stall holds.
  always_comb begin
    rr_d = rr_q;
    pc_d = pc_q;
    if (rn.flush || (!rn.dis_stall && shortfall)) begin
      for (int k = 0; k < WIDTH; k++) rr_d[k].inst_valid = 1'b0;
    end else if (!rn.dis_stall) begin
      for (int k = 0; k < WIDTH; k++) begin
        rr_d[k].alu_op     = rn.rn_inst[k].alu_op;
        rr_d[k].reg_w      = rn.rn_inst[k].reg_w;
        rr_d[k].inst_valid = rn.rn_inst[k].inst_valid;
        rr_d[k].extend_imm = rn.rn_inst[k].extend_imm;
        rr_d[k].psrc1      = psrc1[k];
        rr_d[k].psrc2      = psrc2[k];
        rr_d[k].pdst       = pdst[k];
        rr_d[k].old_pdst   = old_pdst[k];
      end
      pc_d = rn.rn_inst1_pc;
    end
  end

  assign rn.rr_inst     = rr_q;
  assign rn.rr_inst1_pc = pc_q;

  // State register: identity maps and cleared outputs on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        rat_q[i]  <= ptag_t'(i);
        rrat_q[i] <= ptag_t'(i);
      end
      rr_q <= '0;
      pc_q <= '0;
    end else begin
      rat_q  <= rat_d;
      rrat_q <= rrat_d;
      rr_q   <= rr_d;
      pc_q   <= pc_d;
    end
  end

endmodule
